irrigation_zone_scheduler: RTL and testbench

- Parametrised multi-zone successor to the single-zone irrigation controller.
- Shares one water tank (sensors h/m/l) across NZONES zones, each with its own soil, air and temperature sensors.
- Grants the tank to one zone at a time in round-robin order, runs a timed drip or spray cycle, and pauses or aborts on water or sensor faults.
- Drives the tank inlet valve with hysteresis and exposes the active zone and remaining seconds for the display and timer logic.

---
 rtl/irrigation_zone_scheduler.sv | 148 ++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin irrigation scheduler: one shared tank feeding NZONES drip/spray zones.
// Sensors are double-flopped; the tank inlet valve runs with level hysteresis.
module irrigation_zone_scheduler #(
    parameter int unsigned NZONES     = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned DRIP_SECS  = 10,
    parameter int unsigned SPRAY_SECS = 6,
    parameter int unsigned TW         = 8,
    localparam int unsigned ZW        = (NZONES > 1) ? $clog2(NZONES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              h,
    input  logic              m,
    input  logic              l,
    input  logic [NZONES-1:0] us,
    input  logic [NZONES-1:0] ua,
    input  logic [NZONES-1:0] t,
    output logic              alarme,
    output logic              ValvulaEntrada,
    output logic [NZONES-1:0] valve_drip,
    output logic [NZONES-1:0] valve_spray,
    output logic [ZW-1:0]     active_zone,
    output logic [TW-1:0]     remaining,
    output logic              busy
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = 3 + 3 * NZONES;

    typedef enum logic [1:0] {StIdle, StWater, StPause, StDone} state_e;

    logic [SW-1:0]     sync1_q, sync2_q;
    logic              h_s, m_s, l_s;
    logic [NZONES-1:0] us_s, ua_s, t_s;
    logic              alarm_c, inlet_d, tick, cur_water;
    logic [CW-1:0]     cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [ZW-1:0]     zone_q, zone_d, ptr_q, ptr_d, cand;
    logic              spray_q, spray_d, cand_spray, cand_water, hit;
    logic [TW-1:0]     rem_q, rem_d;
    logic [NZONES-1:0] drip_d, spv_d;
    int unsigned       cand_sum;

    assign {h_s, m_s, l_s, us_s, ua_s, t_s} = sync2_q;

    assign alarm_c   = (h_s & ~m_s) | (m_s & ~l_s) | (h_s & ~l_s);
    assign cur_water = ~alarm_c & (spray_q ? m_s : l_s);
    // Clear wins so an inconsistent level reading never opens the inlet.
    assign inlet_d   = (h_s | alarm_c) ? 1'b0 : (~m_s ? 1'b1 : ValvulaEntrada);

    assign tick  = (cnt_q == CW'(TICK_DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + CW'(1);

    assign active_zone = zone_q;
    assign remaining   = rem_q;
    assign busy        = (state_q == StWater) || (state_q == StPause);

    always_comb begin
        state_d    = state_q;
        zone_d     = zone_q;
        spray_d    = spray_q;
        rem_d      = rem_q;
        ptr_d      = ptr_q;
        hit        = 1'b0;
        cand       = '0;
        cand_sum   = 0;
        cand_spray = 1'b0;
        cand_water = 1'b0;
        drip_d     = '0;
        spv_d      = '0;

        unique case (state_q)
            StIdle: begin
                for (int unsigned k = 0; k < NZONES; k++) begin
                    cand_sum = 32'(ptr_q) + k;
                    if (cand_sum >= NZONES) cand_sum = cand_sum - NZONES;
                    cand       = ZW'(cand_sum);
                    cand_spray = ~ua_s[cand] & ~t_s[cand];
                    cand_water = ~alarm_c & (cand_spray ? m_s : l_s);
                    if (!hit && us_s[cand] && cand_water) begin
                        hit     = 1'b1;
                        zone_d  = cand;
                        spray_d = cand_spray;
                        rem_d   = cand_spray ? TW'(SPRAY_SECS) : TW'(DRIP_SECS);
                        state_d = StWater;
                    end
                end
            end
            StWater: begin
                // Request withdrawal beats water loss; water loss beats the tick.
                if (!us_s[zone_q]) begin
                    state_d = StDone;
                end else if (!cur_water) begin
                    state_d = StPause;
                end else if (tick) begin
                    rem_d = rem_q - TW'(1);
                    if (rem_q == TW'(1)) state_d = StDone;
                end
            end
            StPause: begin
                if (!us_s[zone_q]) state_d = StDone;
                else if (cur_water) state_d = StWater;
            end
            StDone: begin
                ptr_d   = (zone_q == ZW'(NZONES - 1)) ? '0 : zone_q + ZW'(1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StDone) rem_d = '0;

        if (state_d == StWater) begin
            if (spray_d) spv_d[zone_d] = 1'b1;
            else drip_d[zone_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            alarme         <= 1'b0;
            ValvulaEntrada <= 1'b0;
            cnt_q          <= '0;
            state_q        <= StIdle;
            zone_q         <= '0;
            ptr_q          <= '0;
            spray_q        <= 1'b0;
            rem_q          <= '0;
            valve_drip     <= '0;
            valve_spray    <= '0;
        end else begin
            sync1_q        <= {h, m, l, us, ua, t};
            sync2_q        <= sync1_q;
            alarme         <= alarm_c;
            ValvulaEntrada <= inlet_d;
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            zone_q         <= zone_d;
            ptr_q          <= ptr_d;
            spray_q        <= spray_d;
            rem_q          <= rem_d;
            valve_drip     <= drip_d;
            valve_spray    <= spv_d;
        end
    end
endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Bench for irrigation_zone_scheduler: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the scheduling rules.
module tb_irrigation_zone_scheduler;
    localparam int unsigned NZ    = 4;
    localparam int unsigned TD    = 4;
    localparam int unsigned DRIP  = 10;
    localparam int unsigned SPRAY = 6;
    localparam int unsigned TW    = 8;

    localparam int PIdle  = 0;
    localparam int PWater = 1;
    localparam int PPause = 2;
    localparam int PDone  = 3;

    logic          clk, rst, h, m, l;
    logic [NZ-1:0] us, ua, t;
    logic          alarme, ValvulaEntrada, busy;
    logic [NZ-1:0] valve_drip, valve_spray;
    logic [1:0]    active_zone;
    logic [TW-1:0] remaining;

    irrigation_zone_scheduler #(
        .NZONES(NZ), .TICK_DIV(TD), .DRIP_SECS(DRIP), .SPRAY_SECS(SPRAY), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst), .h(h), .m(m), .l(l), .us(us), .ua(ua), .t(t),
        .alarme(alarme), .ValvulaEntrada(ValvulaEntrada), .valve_drip(valve_drip),
        .valve_spray(valve_spray), .active_zone(active_zone), .remaining(remaining),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    typedef struct packed {
        logic h, m, l;
        logic [NZ-1:0] us, ua, t;
    } samp_t;

    // Model: inputs become visible two edges late; phase is the scheduler's activity.
    samp_t hist0, hist1;
    int ph, zone, ptr, rem, edges;
    bit spray, inlet, alarm_e;

    int order[$];
    bit pb;
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = PIdle; zone = 0; ptr = 0; rem = 0; edges = 0;
        spray = 0; inlet = 0; alarm_e = 0;
        hist0 = '0; hist1 = '0;
    endtask

    task automatic model_step();
        samp_t s;
        bit alarm, tick, ok, sp;
        int z;
        if (rst) begin
            model_reset();
            return;
        end
        s = hist1;
        alarm = (s.h && !s.m) || (s.m && !s.l) || (s.h && !s.l);
        tick = (edges % TD) == TD - 1;
        edges++;
        case (ph)
            PIdle: begin
                for (int k = 0; k < NZ; k++) begin
                    z = (ptr + k) % NZ;
                    sp = !s.ua[z] && !s.t[z];
                    if (s.us[z] && !alarm && (sp ? s.m : s.l)) begin
                        ph = PWater; zone = z; spray = sp;
                        rem = sp ? SPRAY : DRIP;
                        break;
                    end
                end
            end
            PWater, PPause: begin
                ok = !alarm && (spray ? s.m : s.l);
                if (!s.us[zone]) ph = PDone;
                else if (!ok) ph = PPause;
                else if (ph == PPause) ph = PWater;
                else if (tick) begin
                    rem--;
                    if (rem == 0) ph = PDone;
                end
            end
            default: begin
                ptr = (zone + 1) % NZ;
                ph = PIdle;
            end
        endcase
        if (ph == PDone) rem = 0;
        if (s.h || alarm) inlet = 0;
        else if (!s.m) inlet = 1;
        alarm_e = alarm;
        hist1 = hist0;
        hist0 = {h, m, l, us, ua, t};
    endtask

    always @(negedge clk) begin
        logic [NZ-1:0] ed, es;
        if (cmp_en) begin
            ed = '0;
            es = '0;
            if (ph == PWater) begin
                if (spray) es[zone] = 1'b1;
                else ed[zone] = 1'b1;
            end
            check("alarme", alarme, alarm_e);
            check("inlet", ValvulaEntrada, inlet);
            check("valve_drip", valve_drip, ed);
            check("valve_spray", valve_spray, es);
            check("active_zone", active_zone, zone);
            check("remaining", remaining, rem);
            check("busy", busy, (ph == PWater) || (ph == PPause));
            check("one_hot", $countones({valve_drip, valve_spray}) <= 1, 1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            model_step();
            @(negedge clk);
            #1;
        end
    endtask

    // sel: 0 busy, 1 remaining, 2 valve_drip, 3 valve_spray
    task automatic wait_for(input int sel, input logic [31:0] val, input int budget,
                            input string name);
        logic [31:0] cur;
        int i = 0;
        forever begin
            case (sel)
                0: cur = 32'(busy);
                1: cur = 32'(remaining);
                2: cur = 32'(valve_drip);
                default: cur = 32'(valve_spray);
            endcase
            if (cur == val || i >= budget) break;
            cyc(1);
            i++;
        end
        check(name, cur, val);
    endtask

    initial begin
        rst = 1; h = 0; m = 0; l = 0; us = 0; ua = 0; t = 0;
        model_reset();
        @(negedge clk);
        #1;
        check("rst_alarme", alarme, 0);
        check("rst_inlet", ValvulaEntrada, 0);
        check("rst_drip", valve_drip, 0);
        check("rst_spray", valve_spray, 0);
        check("rst_busy", busy, 0);
        check("rst_rem", remaining, 0);
        check("rst_zone", active_zone, 0);
        cmp_en = 1;
        cyc(2);
        rst = 0;

        // Alarm and inlet hysteresis
        h = 1; m = 0; l = 1;
        cyc(3);
        check("alarm_set", alarme, 1);
        check("inlet_alarm", ValvulaEntrada, 0);
        h = 0; m = 0; l = 1;
        cyc(3);
        check("alarm_clear", alarme, 0);
        check("inlet_open", ValvulaEntrada, 1);
        m = 1;
        cyc(3);
        check("inlet_hold", ValvulaEntrada, 1);
        h = 1;
        cyc(3);
        check("inlet_close", ValvulaEntrada, 0);

        // Single drip cycle on zone 0
        h = 0; us = 4'b0001; ua = 4'b0001; t = 0;
        wait_for(2, 32'h1, 20, "drip_start");
        check("drip_rem", remaining, DRIP);
        check("drip_zone", active_zone, 0);
        wait_for(0, 0, 100, "drip_end");
        check("drip_end_valve", valve_drip, 0);
        check("drip_end_rem", remaining, 0);
        us = 0;
        cyc(8);

        // Spray on zone 2 with a pause at remaining=3
        us = 4'b0100; ua = 0; t = 0;
        wait_for(3, 32'h4, 20, "spray_start");
        check("spray_rem", remaining, SPRAY);
        wait_for(1, 3, 100, "spray_at3");
        m = 0;
        cyc(3);
        check("pause_valve", valve_spray, 0);
        check("pause_busy", busy, 1);
        check("pause_rem", remaining, 3);
        cyc(12);
        check("pause_hold", remaining, 3);
        m = 1;
        wait_for(3, 32'h4, 20, "resume");
        wait_for(0, 0, 100, "spray_end");
        check("spray_end_rem", remaining, 0);
        us = 0;
        cyc(8);

        // Early abort on zone 1 at remaining=5
        us = 4'b0010; ua = 4'b0010;
        wait_for(2, 32'h2, 20, "abort_start");
        wait_for(1, 5, 100, "abort_at5");
        us = 0;
        cyc(3);
        check("abort_busy", busy, 0);
        check("abort_rem", remaining, 0);
        check("abort_valve", valve_drip, 0);
        cyc(3);
        us = 4'b0101; ua = 4'b0101;
        wait_for(0, 1, 20, "next_start");
        check("ptr_after_abort", active_zone, 2);

        // Asynchronous reset between clock edges
        #2;
        rst = 1;
        model_reset();
        #1;
        check("arst_drip", valve_drip, 0);
        check("arst_spray", valve_spray, 0);
        check("arst_busy", busy, 0);
        check("arst_alarme", alarme, 0);
        @(negedge clk);
        #1;
        cyc(2);
        us = 4'b1111; ua = 4'b1111;
        rst = 0;

        // Round-robin from pointer 0
        pb = 0;
        for (int i = 0; i < 600 && order.size() < 5; i++) begin
            cyc(1);
            if (busy && !pb) order.push_back(int'(active_zone));
            pb = busy;
        end
        check("rr_count", order.size(), 5);
        for (int k = 0; k < order.size() && k < 5; k++) check("rr_order", order[k], exp_rr[k]);
        us = 0;
        wait_for(0, 0, 60, "rr_stop");
        cyc(6);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 4))
                    0: {h, m, l} = 3'b000;
                    1: {h, m, l} = 3'b001;
                    2: {h, m, l} = 3'b011;
                    3: {h, m, l} = 3'b111;
                    default: {h, m, l} = 3'($urandom);
                endcase
            end
            if ($urandom_range(0, 15) == 0) us = NZ'($urandom);
            if ($urandom_range(0, 15) == 0) ua = NZ'($urandom);
            if ($urandom_range(0, 15) == 0) t = NZ'($urandom);
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
